// File: rtl/fetch_unit_redirect.sv
// Sequential instruction fetch with in-order sequence-number tagging, commit-driven
// window release, and redirect that squashes every response still in flight.
module fetch_unit_redirect #(
  parameter logic [31:0] p_rst_addr      = 32'h200,
  parameter int unsigned p_seq_num_bits  = 5,
  parameter int unsigned p_max_in_flight = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req_val,
  input  logic                      mem_req_rdy,
  output logic [31:0]               mem_req_addr,
  input  logic                      mem_resp_val,
  output logic                      mem_resp_rdy,
  input  logic [31:0]               mem_resp_addr,
  input  logic [31:0]               mem_resp_data,
  output logic                      d_val,
  input  logic                      d_rdy,
  output logic [31:0]               d_inst,
  output logic [31:0]               d_pc,
  output logic [p_seq_num_bits-1:0] d_seq_num,
  input  logic                      redirect_val,
  input  logic [31:0]               redirect_target,
  input  logic [p_seq_num_bits-1:0] redirect_seq_num,
  input  logic                      commit_val
);

  localparam int unsigned IfW = $clog2(p_max_in_flight + 1);
  localparam int unsigned SqW = p_seq_num_bits;
  localparam int unsigned LcW = p_seq_num_bits + 1;
  localparam logic [IfW-1:0] MaxIf   = IfW'(p_max_in_flight);
  localparam logic [LcW-1:0] WinSize = LcW'(1) << SqW;

  logic [31:0]    r_curr_addr;
  logic [IfW-1:0] r_in_flight;
  logic [IfW-1:0] r_drop_cnt;
  logic [SqW-1:0] r_alloc_ptr;
  logic [SqW-1:0] r_oldest_ptr;
  logic [LcW-1:0] r_live_cnt;

  logic           w_room;
  logic           w_drop_mode;
  logic           w_req_xfer;
  logic           w_resp_xfer;
  logic           w_d_xfer;
  logic           w_commit;
  logic [IfW-1:0] w_in_flight_nxt;
  logic [SqW-1:0] w_oldest_nxt;
  logic [SqW-1:0] w_redir_live;

  // Response path is purely combinational: memory word goes straight to Decode.
  assign w_room      = r_live_cnt < WinSize;
  assign w_drop_mode = (r_drop_cnt != '0) || redirect_val;

  assign mem_req_val  = !rst && !redirect_val && (r_in_flight < MaxIf);
  assign mem_req_addr = r_curr_addr;
  assign mem_resp_rdy = !rst && (w_drop_mode || (d_rdy && w_room));
  assign d_val        = !rst && !w_drop_mode && mem_resp_val && w_room;
  assign d_inst       = mem_resp_data;
  assign d_pc         = mem_resp_addr;
  assign d_seq_num    = r_alloc_ptr;

  assign w_req_xfer  = mem_req_val && mem_req_rdy;
  assign w_resp_xfer = mem_resp_val && mem_resp_rdy;
  assign w_d_xfer    = d_val && d_rdy;
  assign w_commit    = commit_val && (r_live_cnt != '0);

  assign w_in_flight_nxt = r_in_flight + IfW'(w_req_xfer) - IfW'(w_resp_xfer);
  assign w_oldest_nxt    = r_oldest_ptr + SqW'(w_commit);
  assign w_redir_live    = redirect_seq_num + SqW'(1) - w_oldest_nxt;

  // Redirect overrides address, drop, allocation and occupancy updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_curr_addr  <= p_rst_addr;
      r_in_flight  <= '0;
      r_drop_cnt   <= '0;
      r_alloc_ptr  <= '0;
      r_oldest_ptr <= '0;
      r_live_cnt   <= '0;
    end else begin
      r_in_flight  <= w_in_flight_nxt;
      r_oldest_ptr <= w_oldest_nxt;
      if (redirect_val) begin
        r_curr_addr <= redirect_target;
        r_drop_cnt  <= r_in_flight - IfW'(w_resp_xfer);
        r_alloc_ptr <= redirect_seq_num + SqW'(1);
        r_live_cnt  <= {1'b0, w_redir_live};
      end else begin
        if (w_req_xfer) r_curr_addr <= r_curr_addr + 32'd4;
        if (w_resp_xfer && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - IfW'(1);
        if (w_d_xfer) r_alloc_ptr <= r_alloc_ptr + SqW'(1);
        r_live_cnt <= r_live_cnt + LcW'(w_d_xfer) - LcW'(w_commit);
      end
    end
  end

  a_commit_live: assert property (@(posedge clk) disable iff (rst)
    commit_val |-> (r_live_cnt != '0));

endmodule

// File: tb/tb_fetch_unit_redirect.sv
// Directed bench for fetch_unit_redirect: cycle table for streaming/window-full,
// hand sequences for in-flight limit, redirect, stall and redirect+commit.
module tb_fetch_unit_redirect;

  localparam int unsigned SqW = 2;
  localparam logic [31:0] DataKey = 32'hC0DE_0000;

  logic           clk = 1'b0;
  logic           rst;
  logic           mem_req_val, mem_req_rdy;
  logic [31:0]    mem_req_addr;
  logic           mem_resp_val, mem_resp_rdy;
  logic [31:0]    mem_resp_addr, mem_resp_data;
  logic           d_val, d_rdy;
  logic [31:0]    d_inst, d_pc;
  logic [SqW-1:0] d_seq_num;
  logic           redirect_val;
  logic [31:0]    redirect_target;
  logic [SqW-1:0] redirect_seq_num;
  logic           commit_val;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem_q[$];
  bit resp_en;

  fetch_unit_redirect #(
    .p_rst_addr(32'h200), .p_seq_num_bits(SqW), .p_max_in_flight(4)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data),
    .d_val(d_val), .d_rdy(d_rdy), .d_inst(d_inst), .d_pc(d_pc), .d_seq_num(d_seq_num),
    .redirect_val(redirect_val), .redirect_target(redirect_target),
    .redirect_seq_num(redirect_seq_num), .commit_val(commit_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          req_rdy;
    bit          rsp_en;
    bit          drdy;
    bit          commit;
    bit          e_rv;
    logic [31:0] e_ra;
    bit          e_dv;
    logic [31:0] e_pc;
    int          e_seq;
    bit          e_rr;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // In-order memory model: head of queue is presented when responses are enabled.
  task automatic drive_mem();
    if (resp_en && mem_q.size() > 0) begin
      mem_resp_val  = 1'b1;
      mem_resp_addr = mem_q[0];
      mem_resp_data = mem_q[0] ^ DataKey;
    end else begin
      mem_resp_val  = 1'b0;
      mem_resp_addr = 32'h0;
      mem_resp_data = 32'h0;
    end
  endtask

  task automatic drv(input bit rr, input bit re, input bit dr, input bit cm,
                     input bit rd, input logic [31:0] tg, input int rs);
    mem_req_rdy      = rr;
    resp_en          = re;
    d_rdy            = dr;
    commit_val       = cm;
    redirect_val     = rd;
    redirect_target  = tg;
    redirect_seq_num = SqW'(rs);
  endtask

  // One cycle: present memory, check at negedge, then advance the memory model.
  task automatic cyc(input string tag, input bit e_rv, input logic [31:0] e_ra,
                     input bit e_dv, input logic [31:0] e_pc, input int e_seq, input bit e_rr);
    bit req_x, resp_x;
    logic [31:0] ra;
    drive_mem();
    @(negedge clk);
    chk({tag, ".req_val"}, 32'(mem_req_val), 32'(e_rv));
    if (e_rv) chk({tag, ".req_addr"}, mem_req_addr, e_ra);
    chk({tag, ".d_val"}, 32'(d_val), 32'(e_dv));
    if (e_dv) begin
      chk({tag, ".d_pc"}, d_pc, e_pc);
      chk({tag, ".d_seq"}, 32'(d_seq_num), 32'(e_seq));
      chk({tag, ".d_inst"}, d_inst, e_pc ^ DataKey);
    end
    chk({tag, ".resp_rdy"}, 32'(mem_resp_rdy), 32'(e_rr));
    req_x  = mem_req_val && mem_req_rdy;
    resp_x = mem_resp_val && mem_resp_rdy;
    ra     = mem_req_addr;
    @(posedge clk);
    #1;
    if (resp_x) void'(mem_q.pop_front());
    if (req_x) mem_q.push_back(ra);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(1, 0, 1, 0, 0, 32'h0, 0);
    mem_q.delete();
    mem_resp_val  = 1'b1;
    mem_resp_addr = 32'h200;
    mem_resp_data = 32'h200 ^ DataKey;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.req_val", 32'(mem_req_val), 32'h0);
    chk("rst.d_val", 32'(d_val), 32'h0);
    chk("rst.resp_rdy", 32'(mem_resp_rdy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_resp_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    // Stream from reset until the 4-entry window fills; one commit frees exactly one slot.
    tbl[0]  = '{1, 1, 1, 0, 1, 32'h200, 0, 32'h000, 0, 1};
    tbl[1]  = '{1, 1, 1, 0, 1, 32'h204, 1, 32'h200, 0, 1};
    tbl[2]  = '{1, 1, 1, 0, 1, 32'h208, 1, 32'h204, 1, 1};
    tbl[3]  = '{1, 1, 1, 0, 1, 32'h20C, 1, 32'h208, 2, 1};
    tbl[4]  = '{1, 1, 1, 0, 1, 32'h210, 1, 32'h20C, 3, 1};
    tbl[5]  = '{1, 1, 1, 0, 1, 32'h214, 0, 32'h000, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 1, 32'h218, 0, 32'h000, 0, 0};
    tbl[7]  = '{1, 1, 1, 1, 1, 32'h21C, 0, 32'h000, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 32'h000, 1, 32'h210, 0, 1};
    tbl[9]  = '{1, 1, 1, 0, 1, 32'h220, 0, 32'h000, 0, 0};
    tbl[10] = '{1, 1, 1, 0, 0, 32'h000, 0, 32'h000, 0, 0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      drv(tbl[i].req_rdy, tbl[i].rsp_en, tbl[i].drdy, tbl[i].commit, 0, 32'h0, 0);
      cyc($sformatf("tbl%0d", i), tbl[i].e_rv, tbl[i].e_ra, tbl[i].e_dv,
          tbl[i].e_pc, tbl[i].e_seq, tbl[i].e_rr);
    end

    // In-flight limit: four requests, then held off until a response transfers.
    do_reset();
    drv(1, 0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) cyc($sformatf("lim%0d", i), 1, 32'h200 + 32'(4 * i), 0, 0, 0, 1);
    cyc("lim4", 0, 0, 0, 0, 0, 1);
    cyc("lim5", 0, 0, 0, 0, 0, 1);
    drv(1, 1, 1, 0, 0, 32'h0, 0);
    cyc("lim6", 0, 0, 1, 32'h200, 0, 1);
    cyc("lim7", 1, 32'h210, 1, 32'h204, 1, 1);

    // Redirect with three requests outstanding: three drops, then target delivered.
    do_reset();
    drv(1, 0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("rd%0d", i), 1, 32'h200 + 32'(4 * i), 0, 0, 0, 1);
    drv(1, 0, 1, 0, 1, 32'h1000, 1);
    cyc("rd3", 0, 0, 0, 0, 0, 1);
    drv(1, 1, 1, 0, 0, 32'h0, 0);
    cyc("rd4", 1, 32'h1000, 0, 0, 0, 1);
    cyc("rd5", 1, 32'h1004, 0, 0, 0, 1);
    cyc("rd6", 1, 32'h1008, 0, 0, 0, 1);
    cyc("rd7", 1, 32'h100C, 1, 32'h1000, 2, 1);
    cyc("rd8", 1, 32'h1010, 1, 32'h1004, 3, 1);

    // Decode stall: response held steady and its sequence number not consumed.
    do_reset();
    drv(1, 1, 1, 0, 0, 32'h0, 0);
    cyc("st0", 1, 32'h200, 0, 0, 0, 1);
    cyc("st1", 1, 32'h204, 1, 32'h200, 0, 1);
    drv(1, 1, 0, 0, 0, 32'h0, 0);
    cyc("st2", 1, 32'h208, 1, 32'h204, 1, 0);
    cyc("st3", 1, 32'h20C, 1, 32'h204, 1, 0);
    cyc("st4", 1, 32'h210, 1, 32'h204, 1, 0);
    cyc("st5", 0, 0, 1, 32'h204, 1, 0);
    cyc("st6", 0, 0, 1, 32'h204, 1, 0);
    drv(1, 1, 1, 0, 0, 32'h0, 0);
    cyc("st7", 0, 0, 1, 32'h204, 1, 1);
    cyc("st8", 1, 32'h214, 1, 32'h208, 2, 1);

    // Redirect + commit + arriving response in one cycle; window then holds two more.
    do_reset();
    drv(1, 1, 1, 0, 0, 32'h0, 0);
    cyc("rc0", 1, 32'h200, 0, 0, 0, 1);
    cyc("rc1", 1, 32'h204, 1, 32'h200, 0, 1);
    cyc("rc2", 1, 32'h208, 1, 32'h204, 1, 1);
    cyc("rc3", 1, 32'h20C, 1, 32'h208, 2, 1);
    drv(1, 1, 1, 1, 1, 32'h2000, 2);
    cyc("rc4", 0, 0, 0, 0, 0, 1);
    drv(1, 1, 1, 0, 0, 32'h0, 0);
    cyc("rc5", 1, 32'h2000, 0, 0, 0, 1);
    cyc("rc6", 1, 32'h2004, 1, 32'h2000, 3, 1);
    cyc("rc7", 1, 32'h2008, 1, 32'h2004, 0, 1);
    cyc("rc8", 1, 32'h200C, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
